// File: rtl/chunked_adder_if.sv
// Start/busy/done handshake bundle for the chunked add/subtract unit.
// The master drives operands and start; the slave returns status and results.
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle add/subtract: one CHUNK-bit ripple slice per clock, LSB first,
// with the inter-slice carry held in a register. Results publish on entry to DONE.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  chunked_adder_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]  k_q, k_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             msb_cin;
  logic [WIDTH-1:0] acc_next;

  // Operands shift right each RUN cycle, so the active slice is always bits [CHUNK-1:0];
  // the finished slice enters the accumulator from the top and ends up in place.
  always_comb begin
    {slice_cout, slice_sum} = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                              + {{CHUNK{1'b0}}, carry_q};
    msb_cin  = slice_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    acc_next = (acc_q >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    k_d     = k_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    accept  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        accept  = bus.start;
        state_d = bus.start ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        state_d = (k_q == LAST_IDX) ? ST_DONE : ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? 1'b1 : bus.cin;
      acc_d   = {WIDTH{1'b0}};
      k_d     = {IDXW{1'b0}};
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      carry_d = slice_cout;
      acc_d   = acc_next;
      k_d     = k_q + IDXW'(1);
      if (k_q == LAST_IDX) begin
        sum_d  = acc_next;
        cout_d = slice_cout;
        ovf_d  = msb_cin ^ slice_cout;
        zero_d = (acc_next == {WIDTH{1'b0}});
      end else begin
        sum_d  = sum_q;
      end
    end else begin
      a_d     = a_q;
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      k_q     <= {IDXW{1'b0}};
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_chunked_adder.sv
// Directed self-checking bench for chunked_adder: 32/8 main instance plus
// 16/16 and 16/1 parameter corners, all on one clock.
module tb_chunked_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst_c;
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   bcnt;
  int   ndone;

  chunked_adder_if #(.WIDTH(32)) if0 ();
  chunked_adder_if #(.WIDTH(16)) if1 ();
  chunked_adder_if #(.WIDTH(16)) if2 ();

  chunked_adder #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .rst(rst0),  .bus(if0));
  chunked_adder #(.WIDTH(16), .CHUNK(16)) dut1 (.clk(clk), .rst(rst_c), .bus(if1));
  chunked_adder #(.WIDTH(16), .CHUNK(1))  dut2 (.clk(clk), .rst(rst_c), .bus(if2));

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    if0.start = 1'b1;
    if0.a     = a;
    if0.b     = b;
    if0.cin   = cin;
    if0.sub   = sub;
  endtask

  // lat = edges after the start edge at which done is seen (0 = first negedge inside)
  task automatic wait_done0(output int l, output int bc);
    @(negedge clk);
    if0.start = 1'b0;
    l  = 0;
    bc = if0.busy ? 1 : 0;
    while (!if0.done && l < 64) begin
      @(negedge clk);
      l++;
      if (if0.busy) bc++;
    end
  endtask

  task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub,
                     output int l, output int bc);
    @(negedge clk);
    drive0(a, b, cin, sub);
    wait_done0(l, bc);
  endtask

  task automatic op_c(input int sel, input logic [15:0] a, input logic [15:0] b, output int l);
    @(negedge clk);
    if (sel == 1) begin
      if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = 1'b0; if1.sub = 1'b0;
    end else begin
      if2.start = 1'b1; if2.a = a; if2.b = b; if2.cin = 1'b0; if2.sub = 1'b0;
    end
    @(negedge clk);
    if1.start = 1'b0;
    if2.start = 1'b0;
    l = 0;
    while (!((sel == 1) ? if1.done : if2.done) && l < 64) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst0 = 1'b1;
    rst_c = 1'b1;
    {if0.start, if0.a, if0.b, if0.cin, if0.sub} = '0;
    {if1.start, if1.a, if1.b, if1.cin, if1.sub} = '0;
    {if2.start, if2.a, if2.b, if2.cin, if2.sub} = '0;
    repeat (3) @(negedge clk);
    check_value("rst_busy", if0.busy, 1'b0);
    check_value("rst_done", if0.done, 1'b0);
    check_value("rst_sum",  if0.sum,  32'h0);
    check_value("rst_flags", {if0.cout, if0.ovf, if0.zero}, 3'b000);
    rst0 = 1'b0;
    rst_c = 1'b0;

    // full carry ripple through every slice
    op0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat, bcnt);
    check_value("carry_lat",  lat,  4);
    check_value("carry_busy", bcnt, 4);
    check_value("carry_sum",  if0.sum, 32'h0);
    check_value("carry_flags", {if0.cout, if0.ovf, if0.zero}, 3'b101);

    op0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat, bcnt);
    check_value("ovf_sum",   if0.sum, 32'h8000_0000);
    check_value("ovf_flags", {if0.cout, if0.ovf, if0.zero}, 3'b010);

    op0(32'h0000_FF00, 32'h0000_0100, 1'b1, 1'b0, lat, bcnt);
    check_value("xslice_sum",   if0.sum, 32'h0001_0001);
    check_value("xslice_flags", {if0.cout, if0.ovf, if0.zero}, 3'b000);

    op0(32'h5, 32'h7, 1'b1, 1'b1, lat, bcnt);
    check_value("sub_neg_sum",   if0.sum, 32'hFFFF_FFFE);
    check_value("sub_neg_flags", {if0.cout, if0.ovf, if0.zero}, 3'b000);

    op0(32'h8000_0000, 32'h1, 1'b0, 1'b1, lat, bcnt);
    check_value("sub_ovf_sum",   if0.sum, 32'h7FFF_FFFF);
    check_value("sub_ovf_flags", {if0.cout, if0.ovf, if0.zero}, 3'b110);

    // start during RUN is ignored
    @(negedge clk);
    drive0(32'h1, 32'h2, 1'b0, 1'b0);
    @(negedge clk);
    if0.start = 1'b0;
    check_value("hold_mid_sum", if0.sum, 32'h7FFF_FFFF);
    @(negedge clk);
    drive0(32'd100, 32'd200, 1'b0, 1'b0);
    wait_done0(lat, bcnt);
    check_value("ign_lat", lat, 2);
    check_value("ign_sum", if0.sum, 32'h3);
    @(negedge clk);
    check_value("ign_idle_busy", if0.busy, 1'b0);

    // back-to-back: start in the done cycle
    op0(32'd10, 32'd20, 1'b0, 1'b0, lat, bcnt);
    check_value("b2b_first_sum", if0.sum, 32'd30);
    drive0(32'h100, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    if0.start = 1'b0;
    check_value("b2b_busy", if0.busy, 1'b1);
    check_value("b2b_hold_sum", if0.sum, 32'd30);
    wait_done0(lat, bcnt);
    check_value("b2b_lat", lat, 3);
    check_value("b2b_sum", if0.sum, 32'h101);

    // reset in the second busy cycle aborts the operation
    @(negedge clk);
    drive0(32'h3, 32'h4, 1'b0, 1'b0);
    @(negedge clk);
    if0.start = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check_value("abort_busy", if0.busy, 1'b0);
    check_value("abort_done", if0.done, 1'b0);
    check_value("abort_sum",  if0.sum,  32'h0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if0.done) ndone++;
    end
    check_value("abort_no_done", ndone, 0);

    // single-slice corner
    op_c(1, 16'h8000, 16'h8000, lat);
    check_value("n1_lat",   lat, 1);
    check_value("n1_sum",   if1.sum, 16'h0);
    check_value("n1_flags", {if1.cout, if1.ovf, if1.zero}, 3'b111);

    // one-bit slices
    op_c(2, 16'h1234, 16'h0FF1, lat);
    check_value("c1_lat",   lat, 16);
    check_value("c1_sum",   if2.sum, 16'h2225);
    check_value("c1_flags", {if2.cout, if2.ovf, if2.zero}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Multi-cycle, parametrised add/subtract unit built from a CHUNK-bit ripple slice.
- Processes one CHUNK-wide slice per clock, LSB first, carrying between slices in a register.
- Sits beside the ALU datapath as the area-lean adder for wide operands (address/offset math, multi-cycle ALU ops).
- Start/busy/done handshake; reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per cycle. WIDTH % CHUNK must equal 0; NCHUNK = WIDTH/CHUNK, and NCHUNK >= 1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  1 selects A-B; 0 selects A+B+cin. Captured on an accepted start.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB. For sub, 1 means no borrow (A >= B unsigned).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, zero=0, internal index and carry = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch A into the operand register.
  - Latch B_eff = sub ? ~b : b.
  - Set carry register c = sub ? 1 : cin.
  - Set index k=0, go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Compute {c', s} = A[k] + B_eff[k] + c, where [k] is the k-th CHUNK slice.
  - Write s into the result slice k; c <= c'.
  - Record the carry into bit CHUNK-1 of the slice; this feeds the ovf calculation on the last slice.
  - If k == NCHUNK-1, go to DONE; otherwise k <= k+1.
- DONE (one cycle): done=1.
  - start=1: accept new operands exactly as from IDLE and go to RUN. This gives back-to-back operation with no bubble.
  - start=0: go to IDLE.
- busy = (state == RUN). done = (state == DONE).
- Latency: start sampled at edge T0 gives busy=1 after T0, done=1 after edge T0+NCHUNK. Throughput is one operation per NCHUNK+1 cycles when back-to-back.
- Result outputs:
  - sum, cout, ovf and zero update only on the edge entering DONE.
  - They hold their values until the next entry to DONE or reset.
  - The partial sum is kept internally and never appears on sum mid-operation.
- Arithmetic: modulo 2^WIDTH. a, b and cin changing after acceptance have no effect.
- start while in RUN is ignored, with no queueing.
- rst mid-operation aborts: next cycle is IDLE with all outputs 0 and no done pulse.
- NCHUNK=1 (CHUNK=WIDTH): one RUN cycle, done one cycle after start is sampled.

Test Plan:
Directed scenarios at WIDTH=32, CHUNK=8 unless stated:
- Add carry through: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> done exactly 4 edges after the start edge; sum=0, cout=1, ovf=0, zero=1. busy high for exactly 4 cycles.
- Signed overflow: a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0, ovf=1, zero=0. Also a=0x0000FF00, b=0x00000100, cin=1 -> sum=0x00010001 (cross-slice carry).
- Subtract: a=5, b=7, sub=1, cin=1 (must be ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Handshake:
  - Pulse start again during the 2nd busy cycle with different operands -> ignored; result matches the first operands.
  - Assert start in the done cycle -> new operation is accepted; busy rises the next cycle.
  - Previous results hold steady until the second done.
- Reset mid-op: assert rst on the 2nd busy cycle -> next cycle busy=0, done=0, sum=0, and no done pulse follows.
- Parameter corners:
  - WIDTH=16, CHUNK=16: 0x8000+0x8000 -> done one cycle after start; sum=0, cout=1, ovf=1, zero=1.
  - WIDTH=16, CHUNK=1: latency of 16 cycles.
